// File: rtl/btn_matrix_scanner_pkg.sv
// Shared definitions for the button matrix scanner.
// Holds the matrix geometry, the column sequencer state encoding and the
// key index helper used by the scanner and its testbench.
package btn_matrix_pkg;

  localparam int N_ROWS = 5;
  localparam int N_COLS = 4;
  localparam int N_KEYS = N_ROWS * N_COLS;

  // IDLE: no column driven (scan_en low); DWELL: a column is driven and dwelling
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } scan_state_e;

  // Key index from matrix position: row-major, N_COLS keys per row
  function automatic int key_idx(input int row, input int col);
    return row * N_COLS + col;
  endfunction

endpackage

// File: rtl/btn_matrix_scanner_if.sv
// Game-logic side of the button matrix scanner.
// Signals:
//   scan_en   - 1 = scanning runs, 0 = matrix idle
//   keys      - debounced key bitmap, 1 = pressed, index = row*4 + col
//   key_down  - 1-cycle pulse per key on debounced press
//   key_up    - 1-cycle pulse per key on debounced release
//   scan_done - 1-cycle pulse when a frame's debounce update is applied
// master = scanner, slave = game logic.
interface btn_matrix_scanner_if;
  import btn_matrix_pkg::*;

  logic              scan_en;
  logic [N_KEYS-1:0] keys;
  logic [N_KEYS-1:0] key_down;
  logic [N_KEYS-1:0] key_up;
  logic              scan_done;

  modport master (input scan_en, output keys, output key_down, output key_up, output scan_done);
  modport slave  (output scan_en, input keys, input key_down, input key_up, input scan_done);

endinterface

// File: rtl/btn_matrix_scanner_debounce.sv
// Per-key frame debouncer.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   raw        - key value captured in the most recent complete frame
//   frame_rdy  - high for one cycle when a complete frame is available
//   state      - debounced key state, 1 = pressed
//   down / up  - 1-cycle pulses on debounced 0->1 / 1->0
// The state flips only after DEBOUNCE_SCANS consecutive frames disagree with it.
module matrix_key_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic frame_rdy,
  output logic state,
  output logic down,
  output logic up
);

  localparam int CNT_W = (DEBOUNCE_SCANS < 1) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             state_r;
  logic             state_nxt_s;
  logic             down_r;
  logic             down_nxt_s;
  logic             up_r;
  logic             up_nxt_s;

  // Frame update: count disagreeing frames, flip and pulse on the last one
  always_comb begin
    cnt_nxt_s   = cnt_r;
    state_nxt_s = state_r;
    down_nxt_s  = 1'b0;
    up_nxt_s    = 1'b0;
    if (frame_rdy) begin
      if (raw != state_r) begin
        // cnt_r == CNT_LAST means this frame brings the count to DEBOUNCE_SCANS
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = raw;
          cnt_nxt_s   = '0;
          down_nxt_s  = raw;
          up_nxt_s    = ~raw;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_nxt_s = '0;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Debounce state, counter and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      state_r <= 1'b0;
      down_r  <= 1'b0;
      up_r    <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      state_r <= state_nxt_s;
      down_r  <= down_nxt_s;
      up_r    <= up_nxt_s;
    end
  end

  assign state = state_r;
  assign down  = down_r;
  assign up    = up_r;

endmodule

// File: rtl/btn_matrix_scanner.sv
// Scan controller for the 5-row x 4-column button matrix.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   row_sense_n  - raw pulled-up row lines, 0 = key closed on driven column
//   col_drive_n  - active-low one-hot column drive, 4'b1111 = none driven
//   bus          - game-logic side (scan_en, keys, key_down, key_up, scan_done)
// Each column is driven for SCAN_DIV cycles; rows are sampled on the last
// dwell cycle. After column 3 the complete frame feeds 20 debouncers.
module btn_matrix_scanner
  import btn_matrix_pkg::*;
#(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_ROWS-1:0]   row_sense_n,
  output logic [N_COLS-1:0]   col_drive_n,
  btn_matrix_scanner_if.master bus
);

  localparam int D_W = $clog2(SCAN_DIV);
  localparam int C_W = $clog2(N_COLS);
  localparam logic [D_W-1:0] D_LAST = D_W'(SCAN_DIV - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(N_COLS - 1);

  logic [N_ROWS-1:0] sync1_r;
  logic [N_ROWS-1:0] row_s_r;
  scan_state_e       state_r;
  scan_state_e       state_nxt_s;
  logic [D_W-1:0]    d_r;
  logic [D_W-1:0]    d_nxt_s;
  logic [C_W-1:0]    c_r;
  logic [C_W-1:0]    c_nxt_s;
  logic [N_COLS-1:0] col_drive_n_r;
  logic [N_COLS-1:0] col_drive_nxt_s;
  logic [N_KEYS-1:0] raw_r;
  logic [N_KEYS-1:0] raw_nxt_s;
  logic              frame_rdy_r;
  logic              frame_rdy_nxt_s;
  logic              scan_done_r;
  logic              sample_s;
  logic [N_KEYS-1:0] keys_s;
  logic [N_KEYS-1:0] key_down_s;
  logic [N_KEYS-1:0] key_up_s;

  // Two-flop synchroniser for the asynchronous row lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= '1;
      row_s_r <= '1;
    end else begin
      sync1_r <= row_sense_n;
      row_s_r <= sync1_r;
    end
  end

  // Sequencer state register plus registered column drive, raw frame and frame flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_DWELL;
      d_r           <= '0;
      c_r           <= '0;
      col_drive_n_r <= 4'b1110;
      raw_r         <= '0;
      frame_rdy_r   <= 1'b0;
      scan_done_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      d_r           <= d_nxt_s;
      c_r           <= c_nxt_s;
      col_drive_n_r <= col_drive_nxt_s;
      raw_r         <= raw_nxt_s;
      frame_rdy_r   <= frame_rdy_nxt_s;
      scan_done_r   <= frame_rdy_r;
    end
  end

  // Next-state: dwell counting and column advance; disable parks at column 0, d=0
  always_comb begin
    state_nxt_s = state_r;
    d_nxt_s     = d_r;
    c_nxt_s     = c_r;
    case (state_r)
      ST_IDLE: begin
        d_nxt_s = '0;
        c_nxt_s = '0;
        if (bus.scan_en) begin
          state_nxt_s = ST_DWELL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DWELL: begin
        if (!bus.scan_en) begin
          state_nxt_s = ST_IDLE;
          d_nxt_s     = '0;
          c_nxt_s     = '0;
        end else if (d_r == D_LAST) begin
          d_nxt_s = '0;
          c_nxt_s = c_r + C_W'(1);
        end else begin
          d_nxt_s = d_r + D_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        d_nxt_s     = '0;
        c_nxt_s     = '0;
      end
    endcase
  end

  // Outputs: column drive for the next state, row sampling, end-of-frame flag
  always_comb begin
    raw_nxt_s       = raw_r;
    frame_rdy_nxt_s = 1'b0;
    sample_s        = (state_r == ST_DWELL) && bus.scan_en && (d_r == D_LAST);
    if (state_nxt_s == ST_DWELL) begin
      col_drive_nxt_s = ~(4'b0001 << c_nxt_s);
    end else begin
      col_drive_nxt_s = 4'b1111;
    end
    if (sample_s) begin
      for (int r = 0; r < N_ROWS; r++) begin
        raw_nxt_s[key_idx(r, int'(c_r))] = ~row_s_r[r];
      end
      frame_rdy_nxt_s = (c_r == C_LAST);
    end else begin
      frame_rdy_nxt_s = 1'b0;
    end
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    matrix_key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw_r[k]),
      .frame_rdy(frame_rdy_r),
      .state    (keys_s[k]),
      .down     (key_down_s[k]),
      .up       (key_up_s[k])
    );
  end

  assign col_drive_n   = col_drive_n_r;
  assign bus.keys      = keys_s;
  assign bus.key_down  = key_down_s;
  assign bus.key_up    = key_up_s;
  assign bus.scan_done = scan_done_r;

endmodule

// File: tb/tb_btn_matrix_scanner.sv
// Self-checking bench for btn_matrix_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2).
// Models the diode matrix and predicts debounced keys from the history of
// complete frames: a key flips once its last DEBOUNCE_SCANS frames all disagree.
module tb_btn_matrix_scanner;
  import btn_matrix_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam logic [19:0] K9  = 20'h00200;
  localparam logic [19:0] KS  = 20'h80001;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  row_sense_n;
  logic [3:0]  col_drive_n;
  logic [19:0] held;

  btn_matrix_scanner_if bus ();

  btn_matrix_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_sense_n(row_sense_n),
    .col_drive_n(col_drive_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Matrix: a row is pulled low when a held key sits on a driven column
  always_comb begin
    row_sense_n = 5'b11111;
    for (int r = 0; r < N_ROWS; r++) begin
      for (int c = 0; c < N_COLS; c++) begin
        if (!col_drive_n[c] && held[r*4 + c]) row_sense_n[r] = 1'b0;
      end
    end
  end

  int          n_total = 0;
  int          n_pass  = 0;
  logic [19:0] mk;
  logic [19:0] hist[$];
  logic [19:0] stray;
  logic [19:0] exp_down;
  logic [19:0] exp_up;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_frame(input logic [19:0] f);
    logic [19:0] nk;
    nk = mk;
    hist.push_back(f);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      for (int k = 0; k < 20; k++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++) begin
          if (hist[j][k] == mk[k]) all_diff = 1'b0;
        end
        if (all_diff) nk[k] = ~mk[k];
      end
    end
    exp_down = nk & ~mk;
    exp_up   = mk & ~nk;
    mk       = nk;
  endtask

  task automatic wait_done(input int limit, output int n, output logic found);
    n     = 0;
    found = 1'b0;
    while (!found && n < limit) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.scan_done === 1'b1) found = 1'b1;
      else stray |= bus.key_down | bus.key_up;
    end
  endtask

  // Called at the negedge of a scan_done cycle: the next frame sees h throughout
  task automatic do_frame(input logic [19:0] h, input string tag);
    int   n;
    logic f;
    held  = h;
    stray = '0;
    wait_done(40, n, f);
    check({tag, "_done_seen"}, 32'(f), 32'd1);
    check({tag, "_period"}, 32'(n), 32'd16);
    model_frame(h);
    check({tag, "_keys"}, 32'(bus.keys), 32'(mk));
    check({tag, "_down"}, 32'(bus.key_down), 32'(exp_down));
    check({tag, "_up"}, 32'(bus.key_up), 32'(exp_up));
    check({tag, "_stray_pulse"}, 32'(stray), 32'd0);
  endtask

  initial begin
    int          n;
    logic        f;
    logic        saw;
    logic [19:0] h;
    logic [3:0]  exp_col;

    rst         = 1'b1;
    bus.scan_en = 1'b1;
    held        = '0;
    mk          = '0;
    stray       = '0;
    exp_down    = '0;
    exp_up      = '0;
    repeat (3) @(negedge clk);
    check("rst_col", 32'(col_drive_n), 32'h0000_000E);
    check("rst_keys", 32'(bus.keys), 32'd0);
    check("rst_down", 32'(bus.key_down), 32'd0);
    check("rst_up", 32'(bus.key_up), 32'd0);
    check("rst_done", 32'(bus.scan_done), 32'd0);

    // Reset release: column stepping and first-frame latency
    rst = 1'b0;
    check("col_t0", 32'(col_drive_n), 32'h0000_000E);
    for (int t = 1; t < 16; t++) begin
      @(negedge clk);
      if (t % 4 == 0) begin
        exp_col = ~(4'b0001 << (t / 4));
        check("col_step", 32'(col_drive_n), 32'(exp_col));
      end
    end
    wait_done(40, n, f);
    check("first_done_seen", 32'(f), 32'd1);
    check("first_done_latency", 32'(15 + n), 32'd17);
    model_frame('0);
    check("first_keys", 32'(bus.keys), 32'd0);
    do_frame('0, "idle");

    // Press and hold key 9
    do_frame(K9, "press1");
    do_frame(K9, "press2");
    check("press_keys", 32'(bus.keys), 32'(K9));
    check("press_down", 32'(bus.key_down), 32'(K9));

    // Release, then a one-frame glitch
    do_frame('0, "rel1");
    do_frame('0, "rel2");
    check("release_up", 32'(bus.key_up), 32'(K9));
    do_frame(K9, "glitch");
    do_frame('0, "glitch_a");
    do_frame('0, "glitch_b");
    check("glitch_keys", 32'(bus.keys), 32'd0);

    // Two keys closing in the same frame
    do_frame(KS, "sim1");
    do_frame(KS, "sim2");
    check("sim_down", 32'(bus.key_down), 32'h0008_0001);
    check("sim_keys", 32'(bus.keys), 32'h0008_0001);
    do_frame('0, "sim_rel1");
    do_frame('0, "sim_rel2");

    // Random frames, each held for a whole frame
    h = '0;
    repeat (24) begin
      if ($urandom_range(0, 1) == 1) h = 20'($urandom());
      do_frame(h, "rand");
    end
    do_frame('0, "clr1");
    do_frame('0, "clr2");

    // Enable toggle mid-column 2
    do_frame(K9, "en_press1");
    do_frame(K9, "en_press2");
    repeat (8) @(negedge clk);
    check("col2_before_dis", 32'(col_drive_n), 32'h0000_000B);
    bus.scan_en = 1'b0;
    @(negedge clk);
    check("dis_col", 32'(col_drive_n), 32'h0000_000F);
    check("dis_keys", 32'(bus.keys), 32'(mk));
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw |= bus.scan_done | (|bus.key_down) | (|bus.key_up);
    end
    check("dis_quiet", 32'(saw), 32'd0);
    check("dis_col_held", 32'(col_drive_n), 32'h0000_000F);
    bus.scan_en = 1'b1;
    @(negedge clk);
    check("reen_col", 32'(col_drive_n), 32'h0000_000E);
    stray = '0;
    wait_done(40, n, f);
    check("reen_done_seen", 32'(f), 32'd1);
    check("reen_latency", 32'(n), 32'd17);
    model_frame(K9);
    check("reen_keys", 32'(bus.keys), 32'(mk));

    // Async reset in the cycle before a pending release update
    do_frame('0, "pre_rst");
    repeat (15) @(negedge clk);
    check("pre_rst_no_done", 32'(bus.scan_done), 32'd0);
    rst = 1'b1;
    #1;
    check("arst_keys", 32'(bus.keys), 32'd0);
    check("arst_col", 32'(col_drive_n), 32'h0000_000E);
    check("arst_up", 32'(bus.key_up), 32'd0);
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw |= bus.scan_done | (|bus.key_down) | (|bus.key_up);
    end
    check("arst_quiet", 32'(saw), 32'd0);
    rst = 1'b0;
    hist.delete();
    mk    = '0;
    stray = '0;
    wait_done(40, n, f);
    check("post_rst_done_seen", 32'(f), 32'd1);
    check("post_rst_latency", 32'(n), 32'd17);
    check("post_rst_stray", 32'(stray), 32'd0);
    model_frame('0);
    check("post_rst_keys", 32'(bus.keys), 32'(mk));
    check("post_rst_up", 32'(bus.key_up), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
